// File: rtl/piso_tx_pkg.sv
// Shared definitions for the piso_tx serial transmitter and its matching receiver.
// PISO_TX_PARITY_EN widens the state encoding to make room for the PARITY state.
package piso_tx_pkg;

`ifdef PISO_TX_PARITY_EN
    localparam int STATE_W = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } state_e;
`else
    localparam int STATE_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;
`endif

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/d_flip_flop.sv
// Single-bit D flip-flop with asynchronous active-high clear; the storage cell
// shared by the transmit shift register and the receive side.
module d_flip_flop (
    input  logic clk_i,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);

    // Storage bit, cleared asynchronously.
    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            q_o <= 1'b0;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/piso_shreg.sv
// WIDTH-bit loadable right-shift register built from d_flip_flop cells.
// Load has priority over shift; a zero is shifted in at the MSB.
module piso_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] shreg_d;

    // Next value: parallel load, shift right, or hold.
    always_comb begin
        shreg_d = q_o;
        if (load_i) begin
            shreg_d = data_i;
        end else if (shift_i) begin
            shreg_d = {1'b0, q_o[WIDTH-1:1]};
        end else begin
            shreg_d = q_o;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        d_flip_flop u_dff (
            .clk_i (clk_i),
            .clr_i (clr_i),
            .d_i   (shreg_d[i]),
            .q_o   (q_o[i])
        );
    end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out frame transmitter: start bit, WIDTH data bits LSB first,
// optional even parity bit (PISO_TX_PARITY_EN), stop bit.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             sdo,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] shreg_q;
    logic             accept_s;
    logic             shift_s;

    assign accept_s = load_valid & load_ready;
    assign shift_s  = (state_q == DATA);

    piso_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk_i   (clk),
        .clr_i   (clr),
        .load_i  (accept_s),
        .shift_i (shift_s),
        .data_i  (load_data),
        .q_o     (shreg_q)
    );

`ifdef PISO_TX_PARITY_EN
    logic parity_q;

    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    // Parity is fixed at acceptance so it cannot follow later load_data changes.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            parity_q <= 1'b0;
        end else if (accept_s) begin
            parity_q <= even_parity(load_data);
        end else begin
            parity_q <= parity_q;
        end
    end
`endif

    // State and bit-counter registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter is cleared on leaving DATA so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                state_d = DATA;
                cnt_d   = {CNT_W{1'b0}};
            end
            DATA: begin
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cnt_d = {CNT_W{1'b0}};
`ifdef PISO_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = DATA;
                end
            end
`ifdef PISO_TX_PARITY_EN
            PARITY: begin
                state_d = STOP;
            end
`endif
            STOP: begin
                if (accept_s) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        sdo        = STOP_BIT;
        done       = 1'b0;
        busy       = 1'b1;
        load_ready = 1'b0;
        case (state_q)
            IDLE: begin
                busy       = 1'b0;
                load_ready = 1'b1;
            end
            START: begin
                sdo = START_BIT;
            end
            DATA: begin
                sdo = shreg_q[0];
            end
`ifdef PISO_TX_PARITY_EN
            PARITY: begin
                sdo = parity_q;
            end
`endif
            STOP: begin
                done       = 1'b1;
                load_ready = 1'b1;
            end
            default: begin
                sdo        = STOP_BIT;
                busy       = 1'b0;
                load_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_tx.sv
// Directed table-driven bench for piso_tx (WIDTH=8); parity rows appear only
// when PISO_TX_PARITY_EN is defined.
module tb_piso_tx;

    logic       clk;
    logic       clr;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic       sdo;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       sdo;
        logic       done;
        logic       busy;
        logic       rdy;
    } vec_t;

    vec_t tbl[$];

    piso_tx #(.WIDTH(8)) dut (
        .clk        (clk),
        .clr        (clr),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .sdo        (sdo),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_sdo, input logic e_done,
                             input logic e_busy, input logic e_rdy);
        check({tag, ".sdo"}, sdo, e_sdo);
        check({tag, ".done"}, done, e_done);
        check({tag, ".busy"}, busy, e_busy);
        check({tag, ".load_ready"}, load_ready, e_rdy);
    endtask

    // Inputs set on the falling edge, outputs checked 1 time unit after the rising edge.
    task automatic step(input string tag, input logic v, input logic [7:0] d, input logic e_sdo,
                        input logic e_done, input logic e_busy, input logic e_rdy);
        @(negedge clk);
        load_valid = v;
        load_data  = d;
        @(posedge clk);
        #1;
        check_all(tag, e_sdo, e_done, e_busy, e_rdy);
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic s, input logic dn,
                       input logic b, input logic r);
        vec_t e;
        e.v = v; e.d = d; e.sdo = s; e.done = dn; e.busy = b; e.rdy = r;
        tbl.push_back(e);
    endtask

    // seq lists the data bits in transmission order, first bit at seq[7].
    task automatic add_run(input logic v, input logic [7:0] d, input logic [7:0] seq, input int pulse);
        for (int i = 7; i >= 0; i--) begin
            if (pulse == 7 - i) add(1'b1, 8'hFF, seq[i], 1'b0, 1'b1, 1'b0);
            else                add(v, d, seq[i], 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic add_par(input logic v, input logic [7:0] d, input logic p);
`ifdef PISO_TX_PARITY_EN
        add(v, d, p, 1'b0, 1'b1, 1'b0);
`else
        if (p === 1'bx) add(v, d, p, 1'b0, 1'b1, 1'b0);
`endif
    endtask

    initial begin
        // Frame 1: single 0xA5, data bus changed after acceptance.
        add(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        add_run(1'b0, 8'h00, 8'b1010_0101, -1);
        add_par(1'b0, 8'h00, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        // Frame 2: 0xA5 then 0x3C held valid, accepted in the STOP cycle.
        add(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        add_run(1'b1, 8'h3C, 8'b1010_0101, -1);
        add_par(1'b1, 8'h3C, 1'b0);
        add(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1);
        add(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        add_run(1'b0, 8'h00, 8'b0011_1100, -1);
        add_par(1'b0, 8'h00, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        // Frame 3: 0xFF pulse during DATA must be ignored.
        add(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        add_run(1'b0, 8'h00, 8'b1010_0101, 3);
        add_par(1'b0, 8'h00, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        // Frame 4: 0x07, odd weight.
        add(1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 1'b0);
        add_run(1'b0, 8'h00, 8'b1110_0000, -1);
        add_par(1'b0, 8'h00, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);

        clr        = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;

        // Asynchronous reset pulse with no clock edge in between.
        #2 clr = 1'b1;
        #1 check_all("reset", 1'b1, 1'b0, 1'b0, 1'b1);
        #1 clr = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i].v, tbl[i].d, tbl[i].sdo, tbl[i].done,
                 tbl[i].busy, tbl[i].rdy);
        end

        // Mid-frame reset at data bit 3 of 0xA5.
        step("mid.start", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        step("mid.b0", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        step("mid.b1", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        step("mid.b2", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        step("mid.b3", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        clr = 1'b1;
        #1 check_all("mid.clr", 1'b1, 1'b0, 1'b0, 1'b1);
        #1 clr = 1'b0;
        step("mid.idle0", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        step("mid.idle1", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        step("post.start", 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
        step("post.b0", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) begin
            step($sformatf("post.b%0d", i), 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        end
`ifdef PISO_TX_PARITY_EN
        step("post.par", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
`endif
        step("post.stop", 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
        step("post.idle", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
